// File: rtl/mdio_slave_if.sv
// -----------------------------------------------------------------------------
// mdio_slave_if
//   Local-side bus of the MDIO responder: combinational register-file read port
//   plus the write-report signals and frame status.
//   loc_addr     : local read address into the register file
//   loc_rdata    : regfile[loc_addr], combinational
//   wr_stb       : one-mdc-cycle pulse per accepted write
//   wr_addr      : register address of the last accepted write
//   wr_data      : data of the last accepted write
//   frame_active : high whenever the frame decoder is outside IDLE
// -----------------------------------------------------------------------------
interface mdio_slave_if;
   logic [4:0]  loc_addr;
   logic [15:0] loc_rdata;
   logic        wr_stb;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_active;

   modport slave (
      input  loc_addr,
      output loc_rdata, wr_stb, wr_addr, wr_data, frame_active
   );

   modport master (
      output loc_addr,
      input  loc_rdata, wr_stb, wr_addr, wr_data, frame_active
   );
endinterface

// File: rtl/mdio_slave.sv
// -----------------------------------------------------------------------------
// mdio_slave
//   Clause-22 MDIO responder for a single PHY address, backed by a 32 x 16
//   register file. Read frames are answered on the open-drain mdio pin; write
//   frames update the register file and are reported with a one-cycle strobe.
//   Ports:
//     mdc     : MDC, the only clock; all state changes on its rising edge
//     reset_n : asynchronous active-low reset
//     mdio    : open-drain data pin (driven 0 or released)
//     bus     : local side (mdio_slave_if.slave)
//   Build option:
//     MDIO_SLAVE_PREAMBLE_CHECK_EN : when defined, ST is only recognised after
//     a full 32-bit preamble; otherwise a single preceding 1 is enough.
// -----------------------------------------------------------------------------
module mdio_slave #(
   parameter logic [4:0] PHY_ADDR = 5'b00001
) (
   input  logic        mdc,
   input  logic        reset_n,
   inout  wire         mdio,
   mdio_slave_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
   } state_t;

   state_t      r_state,    w_state_nxt;
   logic [5:0]  r_ones_cnt, w_ones_nxt;
   logic [4:0]  r_bit_cnt,  w_cnt_nxt;
   logic        r_rd,       w_rd_nxt;
   logic [4:0]  r_phyad,    w_phyad_nxt;
   logic [4:0]  r_regad,    w_regad_nxt;
   logic [15:0] r_shift,    w_shift_nxt;
   logic        r_oe,       w_oe_nxt;
   logic        r_mdo,      w_mdo_nxt;
   logic        r_wr_stb,   w_wr_stb_nxt;
   logic [4:0]  r_wr_addr,  w_wr_addr_nxt;
   logic [15:0] r_wr_data,  w_wr_data_nxt;
   logic        w_we;
   logic        w_din;
   logic        w_pre_ok;

   logic [15:0] r_regfile [0:31];

   assign w_din = mdio;

`ifdef MDIO_SLAVE_PREAMBLE_CHECK_EN
   assign w_pre_ok = (r_ones_cnt == 6'd32);
`else
   assign w_pre_ok = (r_ones_cnt != 6'd0);
`endif

   // Open-drain: only ever pull low; a 1 is left to the external pull-up.
   assign mdio = (r_oe && !r_mdo) ? 1'b0 : 1'bz;

   assign bus.loc_rdata    = r_regfile[bus.loc_addr];
   assign bus.wr_stb       = r_wr_stb;
   assign bus.wr_addr      = r_wr_addr;
   assign bus.wr_data      = r_wr_data;
   assign bus.frame_active = (r_state != S_IDLE);

   always_comb begin
      w_state_nxt   = r_state;
      w_ones_nxt    = r_ones_cnt;
      w_cnt_nxt     = r_bit_cnt;
      w_rd_nxt      = r_rd;
      w_phyad_nxt   = r_phyad;
      w_regad_nxt   = r_regad;
      w_shift_nxt   = r_shift;
      w_oe_nxt      = r_oe;
      w_mdo_nxt     = r_mdo;
      w_wr_stb_nxt  = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_we          = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_din) begin
               if (r_ones_cnt != 6'd32)
                  w_ones_nxt = r_ones_cnt + 6'd1;
            end else begin
               // ones_cnt is cleared on every 0, so every return to IDLE sees 0
               w_ones_nxt = '0;
               if (w_pre_ok)
                  w_state_nxt = S_ST1;
            end
         end

         S_ST1: begin
            if (w_din) begin
               w_state_nxt = S_OP;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         S_OP: begin
            // First OP bit is parked in r_rd; only 01/10 are legal, so a
            // differing second bit both validates the code and leaves r_rd
            // holding 1 for read.
            if (r_bit_cnt == 5'd0) begin
               w_rd_nxt  = w_din;
               w_cnt_nxt = 5'd1;
            end else if (r_rd != w_din) begin
               w_state_nxt = S_PHYAD;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         S_PHYAD: begin
            w_phyad_nxt = {r_phyad[3:0], w_din};
            if (r_bit_cnt == 5'd4) begin
               w_state_nxt = S_REGAD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_bit_cnt + 5'd1;
            end
         end

         S_REGAD: begin
            w_regad_nxt = {r_regad[3:0], w_din};
            if (r_bit_cnt == 5'd4) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (r_phyad == PHY_ADDR) ? S_TA : S_SKIP;
            end else begin
               w_cnt_nxt = r_bit_cnt + 5'd1;
            end
         end

         S_TA: begin
            if (r_bit_cnt == 5'd0) begin
               w_cnt_nxt = 5'd1;
               if (r_rd) begin
                  w_shift_nxt = r_regfile[r_regad];
                  w_mdo_nxt   = 1'b0;
                  w_oe_nxt    = 1'b1;
               end
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DATA;
               if (r_rd) begin
                  w_mdo_nxt   = r_shift[15];
                  w_shift_nxt = {r_shift[14:0], 1'b0};
               end
            end
         end

         S_DATA: begin
            if (r_rd) begin
               // D15 went out on the last TA edge, so 15 more edges carry
               // D14..D0 and the 16th releases the pin.
               if (r_bit_cnt == 5'd15) begin
                  w_oe_nxt    = 1'b0;
                  w_mdo_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_mdo_nxt   = r_shift[15];
                  w_shift_nxt = {r_shift[14:0], 1'b0};
                  w_cnt_nxt   = r_bit_cnt + 5'd1;
               end
            end else begin
               w_shift_nxt = {r_shift[14:0], w_din};
               if (r_bit_cnt == 5'd15) begin
                  w_we          = 1'b1;
                  w_wr_stb_nxt  = 1'b1;
                  w_wr_addr_nxt = r_regad;
                  w_wr_data_nxt = {r_shift[14:0], w_din};
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_cnt_nxt = r_bit_cnt + 5'd1;
               end
            end
         end

         S_SKIP: begin
            if (r_bit_cnt == 5'd17)
               w_state_nxt = S_IDLE;
            else
               w_cnt_nxt = r_bit_cnt + 5'd1;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge mdc or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_ones_cnt <= '0;
         r_bit_cnt  <= '0;
         r_rd       <= 1'b0;
         r_phyad    <= '0;
         r_regad    <= '0;
         r_shift    <= '0;
         r_oe       <= 1'b0;
         r_mdo      <= 1'b1;
         r_wr_stb   <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ones_cnt <= w_ones_nxt;
         r_bit_cnt  <= w_cnt_nxt;
         r_rd       <= w_rd_nxt;
         r_phyad    <= w_phyad_nxt;
         r_regad    <= w_regad_nxt;
         r_shift    <= w_shift_nxt;
         r_oe       <= w_oe_nxt;
         r_mdo      <= w_mdo_nxt;
         r_wr_stb   <= w_wr_stb_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
      end
   end

   always_ff @(posedge mdc or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 32; i++)
            r_regfile[i] <= '0;
      end else if (w_we) begin
         r_regfile[r_regad] <= w_wr_data_nxt;
      end
   end

endmodule

// File: tb/tb_mdio_slave.sv
// -----------------------------------------------------------------------------
// tb_mdio_slave
//   Self-checking bench for mdio_slave. Acts as an open-drain MDIO master with
//   a pull-up on the line, keeps its own register-file image, and compares the
//   resolved line, write reports, frame status and local reads against it.
//   Honors MDIO_SLAVE_PREAMBLE_CHECK_EN for the short-preamble expectation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdio_slave;

   localparam logic [4:0] PHY = 5'b00001;
`ifdef MDIO_SLAVE_PREAMBLE_CHECK_EN
   localparam bit PRE8_OK = 1'b0;
`else
   localparam bit PRE8_OK = 1'b1;
`endif

   logic mdc;
   logic reset_n;
   logic r_drv0;
   wire  mdio;

   assign mdio = r_drv0 ? 1'b0 : 1'bz;
   pullup (mdio);

   mdio_slave_if bus_if ();

   mdio_slave #(.PHY_ADDR(PHY)) dut (
      .mdc     (mdc),
      .reset_n (reset_n),
      .mdio    (mdio),
      .bus     (bus_if.slave)
   );

   initial mdc = 1'b0;
   always #10 mdc = ~mdc;

   int checks = 0;
   int errors = 0;
   int pulses_seen = 0;
   int pulses_exp  = 0;

   logic [15:0] m_rf [0:31];
   logic [4:0]  m_wa;
   logic [15:0] m_wd;

   always @(negedge mdc)
      if (bus_if.wr_stb === 1'b1) pulses_seen <= pulses_seen + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Sends one frame bit per mdc cycle (changed on the falling edge) and checks
   // the resolved line just before each rising edge.
   task automatic run_frame(input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd,
                            input int pre, input bit exp_stb, input bit exp_resp,
                            input logic [15:0] exp_rd, input bit exp_act,
                            input int abort_at);
      logic mst[$];
      logic expv[$];
      bit   is_wr;
      is_wr = (op == 2'b01);
      for (int i = 0; i < pre; i++) mst.push_back(1'b1);
      mst.push_back(1'b0);
      mst.push_back(1'b1);
      mst.push_back(op[1]);
      mst.push_back(op[0]);
      for (int i = 4; i >= 0; i--) mst.push_back(phy[i]);
      for (int i = 4; i >= 0; i--) mst.push_back(ra[i]);
      mst.push_back(1'b1);
      mst.push_back(is_wr ? 1'b0 : 1'b1);
      for (int i = 15; i >= 0; i--) mst.push_back(is_wr ? wd[i] : 1'b1);
      expv = mst;
      if (exp_resp) begin
         expv[pre + 15] = 1'b0;
         for (int i = 0; i < 16; i++) expv[pre + 16 + i] = exp_rd[15 - i];
      end
      for (int i = 0; i < mst.size(); i++) begin
         @(negedge mdc);
         r_drv0 = !mst[i];
         #5;
         chk("line", {31'd0, mdio}, {31'd0, expv[i]});
         if (i == pre + 14)
            chk("active_mid", {31'd0, bus_if.frame_active}, {31'd0, exp_act});
         if (i == abort_at) return;
      end
      @(negedge mdc);
      r_drv0 = 1'b0;
      #5;
      chk("line_idle", {31'd0, mdio}, 32'd1);
      chk("active_end", {31'd0, bus_if.frame_active}, 32'd0);
      chk("wr_stb", {31'd0, bus_if.wr_stb}, {31'd0, exp_stb});
      if (exp_stb) begin
         m_rf[ra] = wd;
         m_wa     = ra;
         m_wd     = wd;
         pulses_exp++;
      end
      chk("wr_addr", {27'd0, bus_if.wr_addr}, {27'd0, m_wa});
      chk("wr_data", {16'd0, bus_if.wr_data}, {16'd0, m_wd});
      @(negedge mdc);
      #5;
      chk("wr_stb_fall", {31'd0, bus_if.wr_stb}, 32'd0);
      chk("stb_pulses", pulses_seen, pulses_exp);
      bus_if.loc_addr = ra;
      #1;
      chk("loc_rdata", {16'd0, bus_if.loc_rdata}, {16'd0, m_rf[ra]});
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [15:0] wd;
      int          pre;
      bit          exp_stb;
      bit          exp_resp;
      logic [15:0] exp_rd;
      bit          exp_act;
   } vec_t;

   vec_t tbl [0:13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [15:0] wd;
      bit          match;

      //        op     phy       ra     wd        pre stb      resp     rd                         act
      tbl[0]  = '{2'b01, PHY,      5'd4,  16'hABCD, 32, 1'b1,    1'b0,    16'h0000,                  1'b1};
      tbl[1]  = '{2'b10, PHY,      5'd4,  16'h0000, 32, 1'b0,    1'b1,    16'hABCD,                  1'b1};
      tbl[2]  = '{2'b01, 5'b00010, 5'd4,  16'h5555, 32, 1'b0,    1'b0,    16'h0000,                  1'b1};
      tbl[3]  = '{2'b10, 5'b00010, 5'd4,  16'h0000, 32, 1'b0,    1'b0,    16'h0000,                  1'b1};
      tbl[4]  = '{2'b10, PHY,      5'd4,  16'h0000, 32, 1'b0,    1'b1,    16'hABCD,                  1'b1};
      tbl[5]  = '{2'b01, PHY,      5'd31, 16'hFFFF, 32, 1'b1,    1'b0,    16'h0000,                  1'b1};
      tbl[6]  = '{2'b01, PHY,      5'd0,  16'h0001, 32, 1'b1,    1'b0,    16'h0000,                  1'b1};
      tbl[7]  = '{2'b10, PHY,      5'd31, 16'h0000, 32, 1'b0,    1'b1,    16'hFFFF,                  1'b1};
      tbl[8]  = '{2'b10, PHY,      5'd0,  16'h0000, 32, 1'b0,    1'b1,    16'h0001,                  1'b1};
      tbl[9]  = '{2'b01, PHY,      5'd1,  16'h1234,  8, PRE8_OK, 1'b0,    16'h0000,                  PRE8_OK};
      tbl[10] = '{2'b10, PHY,      5'd1,  16'h0000, 32, 1'b0,    1'b1,    PRE8_OK ? 16'h1234 : 16'h0, 1'b1};
      tbl[11] = '{2'b11, 5'b11111, 5'd31, 16'hFFFF, 32, 1'b0,    1'b0,    16'h0000,                  1'b0};
      tbl[12] = '{2'b10, PHY,      5'd4,  16'h0000, 32, 1'b0,    1'b1,    16'hABCD,                  1'b1};
      tbl[13] = '{2'b01, PHY,      5'd6,  16'h1234, 32, 1'b1,    1'b0,    16'h0000,                  1'b1};

      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_wa = '0;
      m_wd = '0;
      r_drv0 = 1'b0;
      reset_n = 1'b0;
      bus_if.loc_addr = '0;

      repeat (3) @(negedge mdc);
      #5;
      chk("rst_line", {31'd0, mdio}, 32'd1);
      chk("rst_stb", {31'd0, bus_if.wr_stb}, 32'd0);
      chk("rst_waddr", {27'd0, bus_if.wr_addr}, 32'd0);
      chk("rst_wdata", {16'd0, bus_if.wr_data}, 32'd0);
      chk("rst_active", {31'd0, bus_if.frame_active}, 32'd0);
      bus_if.loc_addr = 5'd31;
      #1;
      chk("rst_loc31", {16'd0, bus_if.loc_rdata}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++)
         run_frame(tbl[i].op, tbl[i].phy, tbl[i].ra, tbl[i].wd, tbl[i].pre,
                   tbl[i].exp_stb, tbl[i].exp_resp, tbl[i].exp_rd, tbl[i].exp_act, -1);

      // Read reg 6 (0x1234, D8 = 0 so the pin is pulled low) and reset at D8.
      run_frame(2'b10, PHY, 5'd6, 16'h0, 32, 1'b0, 1'b1, 16'h1234, 1'b1, 32 + 16 + 7);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_line", {31'd0, mdio}, 32'd1);
      chk("rst_mid_stb", {31'd0, bus_if.wr_stb}, 32'd0);
      chk("rst_mid_active", {31'd0, bus_if.frame_active}, 32'd0);
      for (int a = 0; a < 32; a++) begin
         bus_if.loc_addr = 5'(a);
         #1;
         chk("rst_mid_loc", {16'd0, bus_if.loc_rdata}, 32'd0);
      end
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_wa = '0;
      m_wd = '0;
      @(negedge mdc);
      r_drv0 = 1'b0;
      #5;
      reset_n = 1'b1;
      run_frame(2'b01, PHY, 5'd9, 16'hC3A5, 32, 1'b1, 1'b0, 16'h0, 1'b1, -1);
      run_frame(2'b10, PHY, 5'd9, 16'h0,    32, 1'b0, 1'b1, 16'hC3A5, 1'b1, -1);

      // Randomized frames against the register-file image.
      for (int n = 0; n < 40; n++) begin
         op    = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
         phy   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY;
         ra    = 5'($urandom);
         wd    = 16'($urandom);
         match = (phy == PHY);
         run_frame(op, phy, ra, wd, 32 + $urandom_range(0, 5),
                   match && (op == 2'b01), match && (op == 2'b10), m_rf[ra], 1'b1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdio_slave.md
# mdio_slave

Clause-22 MDIO responder: the management-device end of the same serial bus our write-only MDIO master drives. It decodes read and write frames on `mdc`/`mdio` for one PHY address and holds a 32 x 16 register file. Reads are returned on the open-drain `mdio` line, and writes are reported to local logic with a one-cycle strobe. It is used to emulate a PHY register map for bring-up and loopback testing of the management path.

## Interface
- `PHY_ADDR`, default 5'b00001: PHY address this block answers to.
- `mdc` in 1: the only clock (MDC, ≤2.5 MHz); all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mdio` inout 1: open-drain; driven 0 or released (z); the resolved pin value is sampled.
- `loc_addr` in 5: local read address into the register file.
- `loc_rdata` out 16: combinational `regfile[loc_addr]`.
- `wr_stb` out 1: one-`mdc`-cycle pulse per accepted write.
- `wr_addr` out 5: register address of the last accepted write.
- `wr_data` out 16: data of the last accepted write.
- `frame_active` out 1: high in any state other than IDLE.

## Operation
- Frame format, MSB first: preamble of 1s, ST = 01, OP (01 = write, 10 = read), PHYAD[4:0], REGAD[4:0], TA (2 bits), DATA[15:0].
- States: IDLE → ST1 → OP → PHYAD → REGAD → TA → DATA → IDLE. A SKIP state is also used (see below).
- IDLE:
  - `ones_cnt` (6 bits, saturates at 32) increments on each sampled 1.
  - A sampled 0 with the preamble condition met (see Configuration) moves to ST1.
  - A sampled 0 without the condition clears `ones_cnt` and stays in IDLE.
- ST1:
  - Sample 1 → OP.
  - Sample 0 → IDLE with `ones_cnt` = 0.
- OP: collect 2 bits. Codes 00 or 11 → IDLE with `ones_cnt` = 0; no response.
- PHYAD and REGAD: collect 5 bits each via a bit counter.
- Address decision, taken on the edge that samples REGAD[0]:
  - PHYAD ≠ `PHY_ADDR` → SKIP, which counts 18 bits (TA + DATA) and then returns to IDLE. `mdio` is never driven in SKIP.
  - PHYAD match → TA.
- Write, PHYAD match:
  - TA bits are sampled and ignored.
  - DATA: 16 bits are shifted in.
  - On the edge sampling D0: `regfile[REGAD]` ← data, `wr_addr`/`wr_data` updated, `wr_stb` = 1 for the following cycle, state → IDLE.
- Read, PHYAD match:
  - The edge sampling TA bit 1 snapshots `regfile[REGAD]` into the shift register and enables the 0 drive for TA bit 2.
  - Each subsequent edge presents the next data bit, D15 first.
  - The edge after D0 is presented releases `mdio` and returns to IDLE.
- Driving rule: `mdio` is driven only when the output bit is 0 and output-enable is set; otherwise it is z. A 1 bit is carried by the external pull-up.
- After every frame (completed, aborted or skipped), `ones_cnt` = 0.
- A local read through `loc_addr` is always available. Local logic cannot write the register file.

## Timing
- Reset values: `mdio` z, `wr_stb` 0, `wr_addr` 0, `wr_data` 0, `frame_active` 0, all `regfile` entries 0, state IDLE, `ones_cnt` 0.
- Reset is asynchronous: asserting it mid-frame releases `mdio` and clears `wr_stb` immediately.
- Let edge k sample REGAD[0]:
  - TA bit 1 is z.
  - Edge k+1 starts driving 0 (TA bit 2).
  - Edges k+2 … k+17 present D15 … D0.
  - Edge k+18 releases `mdio`.
- Output changes only after a rising edge, so each bit is valid at the master's next rising edge.
- Write latency: `wr_stb` rises on the edge that samples D0 and falls on the next edge. `regfile` and `loc_rdata` reflect the new value from that same edge.
- Back-to-back frames: a frame that starts immediately after IDLE is re-entered is accepted if the preamble rule is met.

## Configuration
- `MDIO_SLAVE_PREAMBLE_CHECK_EN` defined: ST is recognised only after `ones_cnt` = 32 (full 32-bit preamble). This prevents false ST detection on data bits of a skipped or aborted frame.
- Not defined: preamble suppression is allowed, and ST is recognised after `ones_cnt` ≥ 1.

## Test plan
- Write with 32-bit preamble, PHYAD 00001, REGAD 00100, data 0xABCD → `wr_stb` high for exactly 1 cycle; `wr_addr` = 4; `wr_data` = 0xABCD; `loc_addr` = 4 gives `loc_rdata` = 0xABCD; `mdio` never driven.
- Read of REGAD 4 after the write above → `mdio` z during TA bit 1, 0 during TA bit 2, then 1,0,1,0,1,0,1,1,1,1,0,0,1,1,0,1 (0xABCD); released at edge k+18; `frame_active` 0 afterwards.
- Read and write frames addressed to PHYAD 00010 → no `wr_stb`, `mdio` z throughout, register file unchanged; a following frame to 00001 is accepted.
- Preamble of 8 ones, then a write of 0x1234 to reg 1 → ignored with the macro defined; accepted (`wr_data` = 0x1234) without it.
- Reset asserted during read bit D8 → `mdio` z within the same cycle; `loc_rdata` = 0 for all addresses; the next valid write frame is accepted.
- OP = 11 frame, then a valid read → no drive during the invalid frame; the valid read returns the correct data.
